// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register, IF/ID pipeline register and the instruction-memory
// request FSM for the IF stage of a 5-stage MIPS pipeline. It applies the
// stall/flush/redirect controls from the hazard unit and runs a req/ready
// handshake to an instruction memory that may insert wait states.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallPC,
    input  logic        stallID,
    input  logic        flushIFID,
    input  logic        pcsel,
    input  logic        jump,
    input  logic        jrjump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_busy
);

    // FETCH: a request for pc is live. DRAIN: a redirect arrived while the
    // request for the old pc was still pending; wait it out and drop its data.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        redir;

    // A stalled ID stage has stale operands, so its redirect must not be taken.
    assign redir    = (jrjump | jump | pcsel) & ~stallPC;
    assign pc_plus4 = pc + 32'd4;

    assign imem_req   = (state == FETCH) || (state == DRAIN);
    assign imem_addr  = pc;
    assign fetch_busy = (state == DRAIN) || !imem_ready;

    // Redirect target selection: jr beats j beats a taken branch.
    always_comb begin
        target = branch_target;
        if (jrjump) begin
            target = jr_target;
        end else if (jump) begin
            target = jump_target;
        end
    end

    // Main FSM: PC, state and IF/ID register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (redir) begin
                            pc <= target;
                        end else if (!stallPC) begin
                            pc <= pc_plus4;
                        end
                        if (!stallID) begin
                            if (flushIFID) begin
                                ifid_instr <= NOP_INSTR;
                                ifid_valid <= 1'b0;
                            end else begin
                                ifid_instr <= imem_rdata;
                                ifid_pc4   <= pc_plus4;
                                ifid_valid <= 1'b1;
                            end
                        end
                    end else begin
                        // pc must stay put until the memory answers.
                        if (!stallID) begin
                            ifid_instr <= NOP_INSTR;
                            ifid_valid <= 1'b0;
                        end
                        if (redir) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!stallID) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        // A redirect arriving on the completion cycle is the newest.
                        pc    <= redir ? target : redir_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Pending redirect target, captured whenever a redirect meets an outstanding fetch.
    always_ff @(posedge clk) begin
        if (redir && !imem_ready) begin
            redir_pc <= target;
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed-vector bench for fetch_stage_ctrl.
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallPC, stallID, flushIFID;
    logic        pcsel, jump, jrjump;
    logic [31:0] branch_target, jump_target, jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallPC      (stallPC),
        .stallID      (stallID),
        .flushIFID    (flushIFID),
        .pcsel        (pcsel),
        .jump         (jump),
        .jrjump       (jrjump),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .jr_target    (jr_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .fetch_busy   (fetch_busy)
    );

    localparam logic [1:0] M_ADDR = 2'b01;  // check imem_addr/fetch_busy before the edge
    localparam logic [1:0] M_PC4  = 2'b10;  // check ifid_pc4 after the edge

    typedef struct {
        logic        rst, spc, sid, fl, ps, jp, jr;
        logic [31:0] bt, jt, jrt;
        logic        rdy;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [1:0]  mask;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic spc, input logic sid, input logic fl,
                       input logic ps, input logic jp, input logic jr, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] e_addr, input logic e_busy,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_valid, input logic [1:0] mask);
        vec_t v;
        v.rst = r; v.spc = spc; v.sid = sid; v.fl = fl;
        v.ps = ps; v.jp = jp; v.jr = jr;
        // Only the highest-priority active target carries tgt; the rest hold decoys.
        v.jrt = jr ? tgt : 32'h0000_7000;
        v.jt  = (jp && !jr) ? tgt : 32'h0000_6000;
        v.bt  = (ps && !jp && !jr) ? tgt : 32'h0000_5000;
        v.rdy = rdy; v.e_addr = e_addr; v.e_busy = e_busy;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.mask = mask;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stallPC = 1'b0; stallID = 1'b0; flushIFID = 1'b0;
        pcsel = 1'b0; jump = 1'b0; jrjump = 1'b0;
        branch_target = 32'h0000_5000; jump_target = 32'h0000_6000; jr_target = 32'h0000_7000;
        imem_ready = 1'b1; imem_rdata = 32'h0;
    endtask

    initial begin
        idle_inputs();
        //   rst spc sid fl ps jp jr tgt           rdy addr          busy instr          pc4           v     mask
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3000,     0, 32'hC0DE3000, 32'h3004,     1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3004,     0, 32'hC0DE3004, 32'h3008,     1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3008,     0, 32'hC0DE3008, 32'h300C,     1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h300C,     0, 32'hC0DE300C, 32'h3010,     1, M_ADDR|M_PC4);
        // stallPC+stallID for two cycles at 0x3010
        add(0, 1, 1, 0, 0, 0, 0, 32'h0,        1, 32'h3010,     0, 32'hC0DE300C, 32'h3010,     1, M_ADDR|M_PC4);
        add(0, 1, 1, 0, 0, 0, 0, 32'h0,        1, 32'h3010,     0, 32'hC0DE300C, 32'h3010,     1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3010,     0, 32'hC0DE3010, 32'h3014,     1, M_ADDR|M_PC4);
        // jump + flush with ready
        add(0, 0, 0, 1, 0, 1, 0, 32'h3100,     1, 32'h3014,     0, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3100,     0, 32'hC0DE3100, 32'h3104,     1, M_ADDR|M_PC4);
        // all three redirects at once: jr wins, goes to 0x3020
        add(0, 0, 0, 1, 1, 1, 1, 32'h3020,     1, 32'h3104,     0, 32'h0,        32'h0,        0, M_ADDR);
        // three wait states at 0x3020
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h3020,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h3020,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h3020,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3020,     0, 32'hC0DE3020, 32'h3024,     1, M_ADDR|M_PC4);
        // redirect mid-wait: branch, then jr overrides, data discarded
        add(0, 0, 0, 0, 1, 0, 0, 32'h3200,     0, 32'h3024,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 1, 32'h3300,     0, 32'h3024,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3024,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3300,     0, 32'hC0DE3300, 32'h3304,     1, M_ADDR|M_PC4);
        // stallPC suppresses a jump; IF/ID still loads (stallID=0)
        add(0, 1, 0, 0, 0, 1, 0, 32'h6000,     1, 32'h3304,     0, 32'hC0DE3304, 32'h3308,     1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3304,     0, 32'hC0DE3304, 32'h3308,     1, M_ADDR|M_PC4);
        // flush without redirect: squash, pc advances
        add(0, 0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h3308,     0, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h330C,     0, 32'hC0DE330C, 32'h3310,     1, M_ADDR|M_PC4);
        // stallID during a wait state holds IF/ID instead of bubbling
        add(0, 0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h3310,     1, 32'hC0DE330C, 32'h3310,     1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3310,     0, 32'hC0DE3310, 32'h3314,     1, M_ADDR|M_PC4);
        // enter DRAIN, then reset while draining
        add(0, 0, 0, 0, 0, 1, 0, 32'h3400,     0, 32'h3314,     1, 32'h0,        32'h0,        0, M_ADDR);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h3314,     1, 32'h0,        32'h0,        0, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h3000,     0, 32'hC0DE3000, 32'h3004,     1, M_ADDR|M_PC4);
        // 32-bit wrap of pc+4
        add(0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFC, 1, 32'h3004,     0, 32'h0,        32'h0,        0, M_ADDR);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'hC0DEFFFC, 32'h0,        1, M_ADDR|M_PC4);
        add(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'hC0DE0000, 32'h4,        1, M_ADDR|M_PC4);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; stallPC = vq[i].spc; stallID = vq[i].sid; flushIFID = vq[i].fl;
            pcsel = vq[i].ps; jump = vq[i].jp; jrjump = vq[i].jr;
            branch_target = vq[i].bt; jump_target = vq[i].jt; jr_target = vq[i].jrt;
            imem_ready = vq[i].rdy;
            imem_rdata = {16'hC0DE, vq[i].e_addr[15:0]};
            #1;
            if (vq[i].mask[0]) begin
                check("imem_addr", i, imem_addr, vq[i].e_addr);
                check("fetch_busy", i, {31'd0, fetch_busy}, {31'd0, vq[i].e_busy});
                check("imem_req", i, {31'd0, imem_req}, 32'd1);
            end
            @(posedge clk);
            #1;
            check("ifid_instr", i, ifid_instr, vq[i].e_instr);
            check("ifid_valid", i, {31'd0, ifid_valid}, {31'd0, vq[i].e_valid});
            if (vq[i].mask[1]) begin
                check("ifid_pc4", i, ifid_pc4, vq[i].e_pc4);
            end
        end

        // Hand sequence: reset during a plain FETCH wait, stale ready ignored.
        @(negedge clk);
        idle_inputs();
        imem_ready = 1'b0;
        #1;
        check("seq_wait_addr", 0, imem_addr, 32'h4);
        check("seq_wait_busy", 0, {31'd0, fetch_busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("seq_rst_addr", 1, imem_addr, 32'h3000);
        check("seq_rst_valid", 1, {31'd0, ifid_valid}, 32'd0);
        check("seq_rst_instr", 1, ifid_instr, 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("seq_first_instr", 2, ifid_instr, 32'h1234_5678);
        check("seq_first_pc4", 2, ifid_pc4, 32'h3004);
        check("seq_next_addr", 2, imem_addr, 32'h3004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog in case the stimulus process stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
